// File: rtl/mvm_dbuf_engine.sv
// Double-buffered signed matrix-vector multiply engine with per-lane strobes,
// output saturation and valid/ready backpressure across a fixed-latency pipeline.
module mvm_dbuf_engine #(
  parameter int unsigned IC_N        = 8,
  parameter int unsigned OC_N        = 8,
  parameter int unsigned WINDOW_SIZE = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    valid_i,
  output logic                                    ready_o,
  input  logic                                    load_mode_i,
  input  logic [IC_N-1:0]                         strobe_i,
  input  logic [IC_N*WINDOW_SIZE*DATA_WIDTH-1:0]  vector_i,
  input  logic                                    swap_i,
  output logic                                    weights_ready_o,
  output logic                                    valid_o,
  input  logic                                    ready_i,
  output logic [OC_N*OUT_WIDTH-1:0]               mvm_o
);

  localparam int unsigned ELEMS = IC_N * WINDOW_SIZE;
  localparam int unsigned ACC_W = 2 * DATA_WIDTH + $clog2(ELEMS);
  localparam int unsigned ROW_W = (OC_N > 1) ? $clog2(OC_N) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // Bank index active_sel is the active bank; the other one is the shadow.
  logic [DATA_WIDTH-1:0]   bank [2][OC_N][ELEMS];
  logic                    active_sel;
  logic [ROW_W-1:0]        wr_row;
  logic                    shadow_full;
  logic                    swap_pending;

  logic signed [ACC_W-1:0] acc [OC_N];
  logic signed [ACC_W-1:0] pipe_acc [PIPE_STAGES][OC_N];
  logic [PIPE_STAGES-1:0]  pipe_vld;
  logic [OC_N*OUT_WIDTH-1:0] sat;

  logic advance, accept, pipe_empty;

  assign advance    = !valid_o || ready_i;
  assign ready_o    = !rst && advance && !swap_pending;
  assign accept     = valid_i && ready_o;
  assign pipe_empty = !(|pipe_vld) && !valid_o;

  always_comb begin
    for (int o = 0; o < OC_N; o++) begin
      acc[o] = '0;
      for (int ic = 0; ic < IC_N; ic++) begin
        for (int wd = 0; wd < WINDOW_SIZE; wd++) begin
          if (strobe_i[ic]) begin
            acc[o] = acc[o]
              + ACC_W'($signed(bank[active_sel][o][ic*WINDOW_SIZE+wd]))
              * ACC_W'($signed(vector_i[(ic*WINDOW_SIZE+wd)*DATA_WIDTH +: DATA_WIDTH]));
          end
        end
      end
    end
  end

  always_comb begin
    sat = '0;
    for (int o = 0; o < OC_N; o++) begin
      if (pipe_acc[PIPE_STAGES-1][o] > SAT_MAX) begin
        sat[o*OUT_WIDTH +: OUT_WIDTH] = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end else if (pipe_acc[PIPE_STAGES-1][o] < SAT_MIN) begin
        sat[o*OUT_WIDTH +: OUT_WIDTH] = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      end else begin
        sat[o*OUT_WIDTH +: OUT_WIDTH] = pipe_acc[PIPE_STAGES-1][o][OUT_WIDTH-1:0];
      end
    end
  end

  // Whole pipeline, including the output register, moves only when advance is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        for (int o = 0; o < OC_N; o++) begin
          pipe_acc[s][o] <= '0;
        end
      end
      valid_o <= 1'b0;
      mvm_o   <= '0;
    end else if (advance) begin
      pipe_vld[0] <= accept && load_mode_i;
      pipe_acc[0] <= acc;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_acc[s] <= pipe_acc[s-1];
      end
      valid_o <= pipe_vld[PIPE_STAGES-1];
      mvm_o   <= sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int o = 0; o < OC_N; o++) begin
          for (int e = 0; e < ELEMS; e++) begin
            bank[b][o][e] <= '0;
          end
        end
      end
      active_sel      <= 1'b0;
      wr_row          <= '0;
      shadow_full     <= 1'b0;
      swap_pending    <= 1'b0;
      weights_ready_o <= 1'b0;
    end else begin
      if (accept && !load_mode_i) begin
        for (int ic = 0; ic < IC_N; ic++) begin
          for (int wd = 0; wd < WINDOW_SIZE; wd++) begin
            if (strobe_i[ic]) begin
              bank[!active_sel][wr_row][ic*WINDOW_SIZE+wd] <=
                vector_i[(ic*WINDOW_SIZE+wd)*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
        if (wr_row == ROW_W'(OC_N - 1)) begin
          wr_row      <= '0;
          shadow_full <= 1'b1;
        end else begin
          wr_row <= wr_row + 1'b1;
        end
      end
      // Loads cannot coincide with a firing swap: ready_o is low while pending.
      if (swap_pending && pipe_empty) begin
        active_sel      <= !active_sel;
        weights_ready_o <= 1'b1;
        shadow_full     <= 1'b0;
        wr_row          <= '0;
        swap_pending    <= 1'b0;
      end else if (swap_i && shadow_full) begin
        swap_pending <= 1'b1;
      end
    end
  end

endmodule
